// File: rtl/regfile_2w_nr_if.sv
// Bus bundle for regfile_2w_nr: two write ports plus NUM_RD packed read ports.
// The master side (writeback/decode) drives writes and read addresses; the register file returns read data.
interface regfile_2w_nr_if #(
    parameter int WIDTH  = 64,
    parameter int DEPTH  = 32,
    parameter int NUM_RD = 2,
    parameter int AW     = $clog2(DEPTH)
);
    logic                         wr_en0;
    logic [AW-1:0]                wr_addr0;
    logic [WIDTH-1:0]             wr_data0;
    logic                         wr_en1;
    logic [AW-1:0]                wr_addr1;
    logic [WIDTH-1:0]             wr_data1;
    logic [NUM_RD-1:0][AW-1:0]    rd_addr;
    logic [NUM_RD-1:0][WIDTH-1:0] rd_data;

    modport master (
        output wr_en0, wr_addr0, wr_data0,
        output wr_en1, wr_addr1, wr_data1,
        output rd_addr,
        input  rd_data
    );

    modport slave (
        input  wr_en0, wr_addr0, wr_data0,
        input  wr_en1, wr_addr1, wr_data1,
        input  rd_addr,
        output rd_data
    );
endinterface

// File: rtl/regfile_2w_nr.sv
// Multi-port register file: two write ports (port 1 wins on collision), NUM_RD combinational
// read ports with optional same-cycle forwarding, and an optional hardwired-zero register.
module regfile_2w_nr #(
    parameter int WIDTH    = 64,
    parameter int DEPTH    = 32,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 31,
    parameter int BYPASS   = 1
) (
    input  logic            clk,
    input  logic            reset,
    regfile_2w_nr_if.slave  bus
);
    localparam int            AW        = $clog2(DEPTH);
    localparam bit            HAS_ZERO  = (ZERO_REG < DEPTH);
    localparam bit            BYPASS_EN = (BYPASS != 0);
    localparam logic [AW-1:0] ZERO_ADDR = AW'(HAS_ZERO ? ZERO_REG : 0);

    logic [WIDTH-1:0]             mem_s [DEPTH];
    logic [NUM_RD-1:0][WIDTH-1:0] rd_data_s;

    for (genvar i = 0; i < DEPTH; i++) begin : g_reg
        if (HAS_ZERO && (i == ZERO_REG)) begin : g_zero
            // The zero register has no flops; it is a constant tie-off.
            assign mem_s[i] = '0;
        end else begin : g_store
            logic [WIDTH-1:0] q_r;
            logic             we0_s;
            logic             we1_s;

            assign we0_s = bus.wr_en0 && (bus.wr_addr0 == AW'(i));
            assign we1_s = bus.wr_en1 && (bus.wr_addr1 == AW'(i));

            // Register storage: reset clears, port 1 takes priority over port 0.
            always_ff @(posedge clk) begin
                if (reset) begin
                    q_r <= '0;
                end else if (we1_s) begin
                    q_r <= bus.wr_data1;
                end else if (we0_s) begin
                    q_r <= bus.wr_data0;
                end else begin
                    q_r <= q_r;
                end
            end

            assign mem_s[i] = q_r;
        end
    end

    // Read mux: zero register first, then forwarded write data (suppressed in reset), then storage.
    always_comb begin
        rd_data_s = '0;
        for (int k = 0; k < NUM_RD; k++) begin
            if (HAS_ZERO && (bus.rd_addr[k] == ZERO_ADDR)) begin
                rd_data_s[k] = '0;
            end else if (BYPASS_EN && !reset && bus.wr_en1 && (bus.wr_addr1 == bus.rd_addr[k])) begin
                rd_data_s[k] = bus.wr_data1;
            end else if (BYPASS_EN && !reset && bus.wr_en0 && (bus.wr_addr0 == bus.rd_addr[k])) begin
                rd_data_s[k] = bus.wr_data0;
            end else begin
                rd_data_s[k] = mem_s[bus.rd_addr[k]];
            end
        end
    end

    assign bus.rd_data = rd_data_s;
endmodule
